// File: rtl/lms_fir_param.sv
// LMS adaptive FIR (noise canceller) with one time-multiplexed multiplier and a valid/ready sample input.
// Build option: define LMS_FREEZE_EN to add i_freeze, which skips the coefficient update for that sample.
module lms_fir_param #(
  parameter int NB_DATA  = 21,
  parameter int NBF_DATA = 20,
  parameter int N_TAPS   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_ref,
  input  logic [NB_DATA-1:0] i_primary,
  input  logic [NB_DATA-1:0] i_mu,
`ifdef LMS_FREEZE_EN
  input  logic               i_freeze,
`endif
  output logic [NB_DATA-1:0] o_err,
  output logic               o_valid
);

  localparam int KW    = $clog2(N_TAPS);
  localparam int PW    = 2 * NB_DATA;
  localparam int ACC_W = 2 * NB_DATA + KW;
  localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-NB_DATA+1){1'b0}}, {(NB_DATA-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ERROR, S_UPDATE} state_t;

  function automatic logic signed [ACC_W-1:0] sx_w(input logic signed [NB_DATA-1:0] v);
    return {{(ACC_W-NB_DATA){v[NB_DATA-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] sx_p(input logic signed [NB_DATA-1:0] v);
    return {{(PW-NB_DATA){v[NB_DATA-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] trunc_frac(input logic signed [ACC_W-1:0] v);
    return v >>> NBF_DATA;
  endfunction

  function automatic logic signed [NB_DATA-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)
      return SAT_HI[NB_DATA-1:0];
    else if (v < SAT_LO)
      return SAT_LO[NB_DATA-1:0];
    else
      return v[NB_DATA-1:0];
  endfunction

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q;
  logic                       last_tap;
  logic                       accept;
  logic                       skip_upd;

  logic signed [NB_DATA-1:0]  x_dl   [N_TAPS];
  logic signed [NB_DATA-1:0]  w_coef [N_TAPS];
  logic signed [ACC_W-1:0]    acc_q;

  logic signed [NB_DATA-1:0]  d_p0;
  logic signed [NB_DATA-1:0]  mu_p0;
  logic signed [NB_DATA-1:0]  g_p1;

  logic signed [NB_DATA-1:0]  mul_a, mul_b;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    prod_acc;
  logic signed [NB_DATA-1:0]  y_c, e_c, g_c, w_upd;

  assign last_tap = (k_q == K_LAST);
  assign accept   = (state_q == S_IDLE) && i_valid;
  assign o_ready  = (state_q == S_IDLE);

`ifdef LMS_FREEZE_EN
  logic freeze_p0;
  assign skip_upd = freeze_p0;
`else
  assign skip_upd = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_valid) state_d = S_FILTER;
      S_FILTER: if (last_tap) state_d = S_ERROR;
      S_ERROR:  state_d = skip_upd ? S_IDLE : S_UPDATE;
      S_UPDATE: if (last_tap) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Shared multiplier: w*x while filtering, mu*e in ERROR, g*x while updating
  always_comb begin
    mul_a = g_p1;
    mul_b = x_dl[k_q];
    case (state_q)
      S_FILTER: mul_a = w_coef[k_q];
      S_ERROR: begin
        mul_a = mu_p0;
        mul_b = e_c;
      end
      default: ;
    endcase
  end

  assign prod     = sx_p(mul_a) * sx_p(mul_b);
  assign prod_acc = {{KW{prod[PW-1]}}, prod};

  assign y_c   = sat_w(trunc_frac(acc_q));
  assign e_c   = sat_w(sx_w(d_p0) - sx_w(y_c));
  assign g_c   = sat_w(trunc_frac(prod_acc));
  assign w_upd = sat_w(sx_w(w_coef[k_q]) + trunc_frac(prod_acc));

  // Stage p0: sample capture, tap walk, accumulate and coefficient write-back
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_dl[i]   <= '0;
        w_coef[i] <= '0;
      end
      acc_q   <= '0;
      k_q     <= '0;
      o_err   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            for (int i = N_TAPS - 1; i > 0; i--)
              x_dl[i] <= x_dl[i-1];
            x_dl[0] <= i_ref;
            acc_q   <= '0;
            k_q     <= '0;
          end
        end
        S_FILTER: begin
          acc_q <= acc_q + prod_acc;
          k_q   <= last_tap ? '0 : k_q + KW'(1);
        end
        S_ERROR: begin
          o_err <= e_c;
          k_q   <= '0;
          if (skip_upd)
            o_valid <= 1'b1;
        end
        S_UPDATE: begin
          w_coef[k_q] <= w_upd;
          k_q         <= last_tap ? '0 : k_q + KW'(1);
          if (last_tap)
            o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: per-sample operands held for the whole filter/update pass
  always_ff @(posedge i_clk) begin
    if (accept) begin
      d_p0  <= i_primary;
      mu_p0 <= i_mu;
`ifdef LMS_FREEZE_EN
      freeze_p0 <= i_freeze;
`endif
    end
    if (state_q == S_ERROR)
      g_p1 <= g_c;
  end

endmodule

// File: tb/tb_lms_fir_param.sv
// Scoreboard bench for lms_fir_param (N_TAPS=4, Q1.20); honours LMS_FREEZE_EN when defined.
module tb_lms_fir_param;

  localparam int NB  = 21;
  localparam int NBF = 20;
  localparam int NT  = 4;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          vld;
  logic          rdy;
  logic          ovld;
  logic [NB-1:0] ref_s, pri_s, mu_s, err;
  logic          frz;

  always #5 tb_clk = ~tb_clk;

  lms_fir_param #(.NB_DATA(NB), .NBF_DATA(NBF), .N_TAPS(NT)) dut (
    .i_clk     (tb_clk),
    .i_rst     (rst),
    .i_valid   (vld),
    .o_ready   (rdy),
    .i_ref     (ref_s),
    .i_primary (pri_s),
    .i_mu      (mu_s),
`ifdef LMS_FREEZE_EN
    .i_freeze  (frz),
`endif
    .o_err     (err),
    .o_valid   (ovld)
  );

  typedef struct {
    logic [NB-1:0] err;
    int            t0;
    int            lat;
    int            id;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_ovld  = 0;
  int     cyc     = 0;
  int     sid     = 0;
  longint mx[NT];
  longint mw[NT];

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx21(input logic [NB-1:0] r);
    longint v;
    v = longint'(r);
    if (r[NB-1]) v = v - (64'sd1 <<< NB);
    return v;
  endfunction

  function automatic longint sat21(input longint v);
    if (v > 1048575) return 1048575;
    if (v < -1048576) return -1048576;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
  endfunction

  function automatic longint model_step(input longint x, input longint d, input longint mu, input bit fr);
    longint acc, y, e, g;
    for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = x;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += mw[i] * mx[i];
    y = sat21(acc >>> NBF);
    e = sat21(d - y);
    g = sat21((mu * e) >>> NBF);
    if (!fr)
      for (int i = 0; i < NT; i++) mw[i] = sat21(mw[i] + ((g * mx[i]) >>> NBF));
    return e;
  endfunction

  always @(negedge tb_clk) begin
    if (!rst && ovld) begin
      exp_t e;
      n_ovld++;
      if (sb.size() == 0) begin
        check("unexpected_ovalid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("err#%0d", e.id), longint'(err), longint'(e.err));
        check($sformatf("latency#%0d", e.id), cyc - e.t0, e.lat);
        check($sformatf("ready_at_ovalid#%0d", e.id), longint'(rdy), 1);
      end
    end
  end

  task automatic send(input logic [NB-1:0] x, input logic [NB-1:0] d, input logic [NB-1:0] mu,
                      input bit fr, input bit use_ovr, input logic [NB-1:0] ovr);
    exp_t   e;
    longint me;
    int     w;
    w = 0;
    @(negedge tb_clk);
    while (!rdy && w < 100) begin
      @(negedge tb_clk);
      w++;
    end
    if (!rdy) begin
      check("ready_timeout", 0, 1);
      return;
    end
    ref_s = x;
    pri_s = d;
    mu_s  = mu;
    frz   = fr;
    vld   = 1'b1;
    me    = model_step(sx21(x), sx21(d), sx21(mu), fr);
    e.err = use_ovr ? ovr : me[NB-1:0];
    e.t0  = cyc;
    e.lat = fr ? NT + 2 : 2 * NT + 2;
    e.id  = sid++;
    sb.push_back(e);
    @(posedge tb_clk);
    #1 vld = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge tb_clk);
      w++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge tb_clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    vld = 1'b0;
    sb.delete();
    model_reset();
    repeat (n) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; vld = 1'b0; frz = 1'b0;
    ref_s = '0; pri_s = '0; mu_s = '0;

    do_reset(5);
    check("rst_err", longint'(err), 0);
    check("rst_ovalid", longint'(ovld), 0);
    check("rst_ready", longint'(rdy), 1);
    n0 = n_ovld;
    repeat (20) @(negedge tb_clk);
    check("idle_no_ovalid", n_ovld - n0, 0);

    send(21'h080000, 21'h040000, 21'h000000, 1'b0, 1'b1, 21'h040000);
    @(negedge tb_clk);
    check("busy_ready_c1", longint'(rdy), 0);
    repeat (4) @(negedge tb_clk);
    check("busy_ready_c5", longint'(rdy), 0);
    wait_drain();

    do_reset(2);
    send(21'h080000, 21'h080000, 21'h080000, 1'b0, 1'b1, 21'h080000);
    send(21'h080000, 21'h080000, 21'h080000, 1'b0, 1'b1, 21'h070000);
    wait_drain();

    send(21'h080000, 21'h100000, 21'h080000, 1'b0, 1'b1, 21'h100000);
    wait_drain();

    n0 = n_ovld;
    send(21'h040000, 21'h020000, 21'h000000, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge tb_clk);
      if (c == 3 || c == 7) begin
        ref_s = 21'h0FFFFF; pri_s = 21'h155555; mu_s = 21'h0C0000;
        vld = 1'b1;
      end else begin
        vld = 1'b0;
      end
    end
    vld = 1'b0;
    wait_drain();
    check("busy_one_ovalid", n_ovld - n0, 1);

    for (int i = 0; i < 12; i++)
      send(NB'($urandom_range(0, 2097151)), NB'($urandom_range(0, 2097151)),
           NB'($urandom_range(0, 2097151)), 1'b0, 1'b0, '0);
    wait_drain();

    send(21'h0A0000, 21'h030000, 21'h080000, 1'b0, 1'b0, '0);
    @(negedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b1;
    sb.delete();
    model_reset();
    n0 = n_ovld;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    rst = 1'b0;
    check("midrst_err", longint'(err), 0);
    check("midrst_ovalid", longint'(ovld), 0);
    check("midrst_ready", longint'(rdy), 1);
    repeat (15) @(negedge tb_clk);
    check("midrst_no_ovalid", n_ovld - n0, 0);
    send(21'h080000, 21'h040000, 21'h000000, 1'b0, 1'b1, 21'h040000);
    wait_drain();

`ifdef LMS_FREEZE_EN
    do_reset(2);
    send(21'h080000, 21'h080000, 21'h080000, 1'b1, 1'b1, 21'h080000);
    send(21'h080000, 21'h080000, 21'h080000, 1'b1, 1'b1, 21'h080000);
    wait_drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
